// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and helpers for the parametrised SDP RAM
package ram_pkg;

    typedef enum logic {CLEAR, READY} state_t;

    // Widest word the byte-merge helper handles; callers size-cast in and out.
    localparam int MAX_W = 256;

    function automatic int byte_cnt(input int w);
        return w / 8;
    endfunction

    function automatic logic [MAX_W-1:0] byte_merge(
        input logic [MAX_W-1:0]   old_word,
        input logic [MAX_W-1:0]   new_word,
        input logic [MAX_W/8-1:0] be
    );
        logic [MAX_W-1:0] res;
        res = old_word;
        for (int i = 0; i < MAX_W / 8; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_sdp_param_if.sv
// rtl/ram_sdp_param_if.sv - write/read port bundle of the SDP RAM
interface ram_sdp_param_if
    import ram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic                        wr;
    logic [ADDR_W-1:0]           waddr;
    logic [DATA_W-1:0]           din;
    logic [byte_cnt(DATA_W)-1:0] be;
    logic                        rd;
    logic [ADDR_W-1:0]           raddr;
    logic [DATA_W-1:0]           dout;
    logic                        dout_valid;
    logic                        busy;

    modport master (
        output wr, waddr, din, be, rd, raddr,
        input  dout, dout_valid, busy
    );

    modport slave (
        input  wr, waddr, din, be, rd, raddr,
        output dout, dout_valid, busy
    );
endinterface

// File: rtl/ram_sdp_param_rd_pipe.sv
// rtl/ram_sdp_param_rd_pipe.sv - 1 or 2 stage read-data pipeline with hold-on-idle output
module ram_rd_pipe #(
    parameter int DATA_W = 8,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);
    logic              mid_valid;
    logic [DATA_W-1:0] mid_data;

    if (LAT == 2) begin : g_two
        logic              v1;
        logic [DATA_W-1:0] d1;

        always_ff @(posedge clk) begin
            if (rst) begin
                v1 <= 1'b0;
                d1 <= '0;
            end else begin
                v1 <= in_valid;
                if (in_valid) begin
                    d1 <= in_data;
                end
            end
        end

        assign mid_valid = v1;
        assign mid_data  = d1;
    end else begin : g_one
        assign mid_valid = in_valid;
        assign mid_data  = in_data;
    end

    // Output register only loads on a completing read so dout holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= mid_valid;
            if (mid_valid) begin
                out_data <= mid_data;
            end
        end
    end
endmodule

// File: rtl/ram_sdp_param.sv
// rtl/ram_sdp_param.sv - simple-dual-port RAM with byte enables, clear sequence and collision policy
module ram_sdp_param
    import ram_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter int                ADDR_W     = 4,
    parameter int                RD_LATENCY = 1,
    parameter int                BYPASS     = 1,
    parameter logic [DATA_W-1:0] INIT_VAL   = '0
) (
    input logic            clk,
    input logic            rst,
    ram_sdp_param_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = byte_cnt(DATA_W);

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $fatal(1, "ram_sdp_param: RD_LATENCY must be 1 or 2");
    end
    if (DATA_W % 8 != 0 || DATA_W > MAX_W) begin : g_bad_width
        $fatal(1, "ram_sdp_param: DATA_W must be a multiple of 8 and <= MAX_W");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              clr_we, wr_en, rd_en, collide;
    logic [DATA_W-1:0] wdata, rdata;
    logic              rq_valid;
    logic [DATA_W-1:0] rq_data;
    logic              pipe_valid;
    logic [DATA_W-1:0] pipe_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (&clr_cnt_q) begin
                state_d = READY;
            end
        end
    end

    assign clr_we  = !rst && (state_q == CLEAR);
    assign wr_en   = !rst && (state_q == READY) && bus.wr;
    assign rd_en   = !rst && (state_q == READY) && bus.rd;
    assign collide = wr_en && rd_en && (bus.waddr == bus.raddr);

    assign wdata = DATA_W'(byte_merge(MAX_W'(mem[bus.waddr]), MAX_W'(bus.din),
                                      (MAX_W/8)'(bus.be)));

    // Write-first forwarding reuses the merged write word; otherwise read-old.
    assign rdata = (BYPASS != 0 && collide) ? wdata : mem[bus.raddr];

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt_q] <= INIT_VAL;
        end else if (wr_en) begin
            mem[bus.waddr] <= wdata;
        end
    end

    // Capturing the word at the request edge isolates it from later writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rq_valid <= 1'b0;
            rq_data  <= '0;
        end else begin
            rq_valid <= rd_en;
            if (rd_en) begin
                rq_data <= rdata;
            end
        end
    end

    ram_rd_pipe #(
        .DATA_W (DATA_W),
        .LAT    (RD_LATENCY)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rq_valid),
        .in_data   (rq_data),
        .out_valid (pipe_valid),
        .out_data  (pipe_data)
    );

    assign bus.dout       = pipe_data;
    assign bus.dout_valid = pipe_valid;
    assign bus.busy       = (state_q == CLEAR);

    logic unused_nb;
    assign unused_nb = (NB == 0);
endmodule

// File: tb/tb_ram_sdp_param.sv
// tb/tb_ram_sdp_param.sv - directed table-driven bench for ram_sdp_param
module tb_ram_sdp_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr = 1'b0, rd = 1'b0;
    logic [3:0]  waddr = '0, raddr = '0;
    logic [15:0] din = '0;
    logic [1:0]  be = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram_sdp_param_if #(.DATA_W(8),  .ADDR_W(4)) if0 ();
    ram_sdp_param_if #(.DATA_W(16), .ADDR_W(4)) if1 ();
    ram_sdp_param_if #(.DATA_W(16), .ADDR_W(4)) if2 ();
    ram_sdp_param_if #(.DATA_W(8),  .ADDR_W(4)) if3 ();

    assign if0.wr = wr;  assign if0.waddr = waddr;  assign if0.din = din[7:0];
    assign if0.be = be[0:0];  assign if0.rd = rd;  assign if0.raddr = raddr;
    assign if1.wr = wr;  assign if1.waddr = waddr;  assign if1.din = din;
    assign if1.be = be;  assign if1.rd = rd;  assign if1.raddr = raddr;
    assign if2.wr = wr;  assign if2.waddr = waddr;  assign if2.din = din;
    assign if2.be = be;  assign if2.rd = rd;  assign if2.raddr = raddr;
    assign if3.wr = wr;  assign if3.waddr = waddr;  assign if3.din = din[7:0];
    assign if3.be = be[0:0];  assign if3.rd = rd;  assign if3.raddr = raddr;

    ram_sdp_param #(.DATA_W(8), .ADDR_W(4), .RD_LATENCY(1), .BYPASS(1), .INIT_VAL(8'h5A))
        u0 (.clk(clk), .rst(rst), .bus(if0));
    ram_sdp_param #(.DATA_W(16), .ADDR_W(4), .RD_LATENCY(1), .BYPASS(1), .INIT_VAL(16'h0000))
        u1 (.clk(clk), .rst(rst), .bus(if1));
    ram_sdp_param #(.DATA_W(16), .ADDR_W(4), .RD_LATENCY(1), .BYPASS(0), .INIT_VAL(16'h0000))
        u2 (.clk(clk), .rst(rst), .bus(if2));
    ram_sdp_param #(.DATA_W(8), .ADDR_W(4), .RD_LATENCY(2), .BYPASS(1), .INIT_VAL(8'h00))
        u3 (.clk(clk), .rst(rst), .bus(if3));

    typedef struct {
        logic        wr;
        logic [3:0]  waddr;
        logic [15:0] din;
        logic [1:0]  be;
        logic        rd;
        logic [3:0]  raddr;
        logic        ev;
        logic [7:0]  e0;
        logic [15:0] e1;
        logic [15:0] e2;
    } vec_t;

    vec_t vt [18];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Counts busy cycles of u0 starting from the reset edge, plus stray dout_valid pulses.
    task automatic count_busy(output int n, output int nv);
        n  = 1;
        nv = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (if0.dout_valid) nv++;
            if (!if0.busy) break;
            n++;
        end
    endtask

    initial begin
        int         n, nv;
        logic [7:0] vpat;

        //          wr wa  din       be    rd ra  ev  u0     u1        u2
        vt[0]  = '{1'b0, 4'h0, 16'h0000, 2'b00, 1'b1, 4'h0, 1'b0, 8'h00, 16'h0000, 16'h0000};
        vt[1]  = '{1'b0, 4'h0, 16'h0000, 2'b00, 1'b1, 4'hF, 1'b1, 8'h5A, 16'h0000, 16'h0000};
        vt[2]  = '{1'b0, 4'h0, 16'h0000, 2'b00, 1'b0, 4'h0, 1'b1, 8'h5A, 16'h0000, 16'h0000};
        vt[3]  = '{1'b1, 4'h2, 16'h00AC, 2'b11, 1'b0, 4'h0, 1'b0, 8'h5A, 16'h0000, 16'h0000};
        vt[4]  = '{1'b1, 4'h3, 16'h00CC, 2'b11, 1'b0, 4'h0, 1'b0, 8'h5A, 16'h0000, 16'h0000};
        vt[5]  = '{1'b0, 4'h0, 16'h0000, 2'b00, 1'b1, 4'h2, 1'b0, 8'h5A, 16'h0000, 16'h0000};
        vt[6]  = '{1'b0, 4'h0, 16'h0000, 2'b00, 1'b1, 4'h3, 1'b1, 8'hAC, 16'h00AC, 16'h00AC};
        vt[7]  = '{1'b1, 4'h2, 16'h00F0, 2'b11, 1'b0, 4'h0, 1'b1, 8'hCC, 16'h00CC, 16'h00CC};
        vt[8]  = '{1'b0, 4'h0, 16'h0000, 2'b00, 1'b1, 4'h2, 1'b0, 8'hCC, 16'h00CC, 16'h00CC};
        vt[9]  = '{1'b0, 4'h0, 16'h0000, 2'b00, 1'b0, 4'h0, 1'b1, 8'hF0, 16'h00F0, 16'h00F0};
        vt[10] = '{1'b1, 4'h5, 16'h1234, 2'b11, 1'b0, 4'h0, 1'b0, 8'hF0, 16'h00F0, 16'h00F0};
        vt[11] = '{1'b1, 4'h5, 16'hABCD, 2'b01, 1'b0, 4'h0, 1'b0, 8'hF0, 16'h00F0, 16'h00F0};
        vt[12] = '{1'b0, 4'h0, 16'h0000, 2'b00, 1'b1, 4'h5, 1'b0, 8'hF0, 16'h00F0, 16'h00F0};
        vt[13] = '{1'b1, 4'h7, 16'h1111, 2'b11, 1'b0, 4'h0, 1'b1, 8'hCD, 16'h12CD, 16'h12CD};
        vt[14] = '{1'b1, 4'h7, 16'h2222, 2'b10, 1'b1, 4'h7, 1'b0, 8'hCD, 16'h12CD, 16'h12CD};
        vt[15] = '{1'b0, 4'h0, 16'h0000, 2'b00, 1'b1, 4'h7, 1'b1, 8'h11, 16'h2211, 16'h1111};
        vt[16] = '{1'b0, 4'h0, 16'h0000, 2'b00, 1'b0, 4'h0, 1'b1, 8'h11, 16'h2211, 16'h2211};
        vt[17] = '{1'b0, 4'h0, 16'h0000, 2'b00, 1'b0, 4'h0, 1'b0, 8'h11, 16'h2211, 16'h2211};

        // Reset state and clear sequence length
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_busy", 32'(if0.busy), 32'd1);
        chk("rst_valid", 32'(if0.dout_valid), 32'd0);
        chk("rst_dout", 32'(if0.dout), 32'h00);
        chk("rst_valid_l2", 32'(if3.dout_valid), 32'd0);
        rst = 1'b0;
        count_busy(n, nv);
        chk("clear_busy_len", 32'(n), 32'd16);

        // Table: reads, writes, byte enables, collisions
        for (int i = 0; i < 18; i++) begin
            wr = vt[i].wr;  waddr = vt[i].waddr;  din = vt[i].din;
            be = vt[i].be;  rd = vt[i].rd;        raddr = vt[i].raddr;
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(if0.dout_valid), 32'(vt[i].ev));
            chk($sformatf("vec%0d_dout8", i), 32'(if0.dout), 32'(vt[i].e0));
            chk($sformatf("vec%0d_dout_byp", i), 32'(if1.dout), 32'(vt[i].e1));
            chk($sformatf("vec%0d_dout_old", i), 32'(if2.dout), 32'(vt[i].e2));
            chk($sformatf("vec%0d_valid_old", i), 32'(if2.dout_valid), 32'(vt[i].ev));
        end
        wr = 1'b0;
        rd = 1'b0;

        // Latency 2: continuous reads of addrs 0..3
        for (int i = 0; i < 4; i++) begin
            wr = 1'b1;  waddr = 4'(i);  din = 16'h0010 + 16'(i);  be = 2'b11;
            tick();
        end
        wr = 1'b0;
        tick();
        vpat = 8'b0011_1100;
        for (int i = 0; i < 8; i++) begin
            rd = (i < 4);
            raddr = 4'(i);
            tick();
            chk($sformatf("lat2_valid%0d", i), 32'(if3.dout_valid), 32'(vpat[i]));
            if (vpat[i]) begin
                chk($sformatf("lat2_data%0d", i), 32'(if3.dout), 32'h10 + 32'(i - 2));
            end
        end
        rd = 1'b0;

        // Reset mid-clear, ops ignored while busy
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wr = 1'b1;  waddr = 4'h1;  din = 16'h00FF;  be = 2'b11;
        rd = 1'b1;  raddr = 4'h1;
        count_busy(n, nv);
        wr = 1'b0;
        rd = 1'b0;
        chk("reclear_busy_len", 32'(n), 32'd16);
        chk("busy_no_valid", 32'(nv), 32'd0);
        rd = 1'b1;
        raddr = 4'h1;
        tick();
        rd = 1'b0;
        tick();
        chk("post_clear_valid", 32'(if0.dout_valid), 32'd1);
        chk("post_clear_dout", 32'(if0.dout), 32'h5A);
        chk("post_clear_dout16", 32'(if1.dout), 32'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
